// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc, instruction} buffer between fetch and decode
// Absorbs decode stalls; flushed on a jump redirect, with flush taking priority over push and pop.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [W-1:0]     in_pc,
  input  logic [W-1:0]     in_instr,
  output logic             in_ready,
  output logic             afull,
  output logic             out_valid,
  output logic [W-1:0]     out_pc,
  output logic [W-1:0]     out_instr,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_AFULL = (PTR_W+1)'(DEPTH - 1);

  logic [W-1:0]   pc_mem    [DEPTH];
  logic [W-1:0]   instr_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic           push;
  logic           pop;

  assign in_ready  = (count != CNT_FULL);
  assign afull     = (count >= CNT_AFULL);
  assign out_valid = (count != '0);
  assign out_pc    = pc_mem[rd_ptr];
  assign out_instr = instr_mem[rd_ptr];

  // A pop never frees a slot for a same-cycle push: in_ready looks only at current count.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= in_pc;
        instr_mem[wr_ptr] <= in_instr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
